logic_cell_cfg_loader: RTL and testbench

//  Serial configuration loader directly upstream of one LOGIC_CELL.

---
 rtl/logic_cell_cfg_loader_if.sv | 22 ++
 rtl/logic_cell_cfg_loader.sv | 132 +++++++++++++
 tb/tb_logic_cell_cfg_loader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/logic_cell_cfg_loader_if.sv
// Serial configuration bus between a config source and one logic_cell_cfg_loader.
// The source owns bit/valid/abort; the loader owns ready.
interface logic_cell_cfg_loader_if;
    logic cfg_bit;
    logic cfg_valid;
    logic cfg_ready;
    logic cfg_abort;

    modport master (
        output cfg_bit,
        output cfg_valid,
        output cfg_abort,
        input  cfg_ready
    );

    modport slave (
        input  cfg_bit,
        input  cfg_valid,
        input  cfg_abort,
        output cfg_ready
    );
endinterface

// File: rtl/logic_cell_cfg_loader.sv
// Deserialises 32-bit LSB-first config frames for one LOGIC_CELL, validates them
// (sync, parity, mode, address) and commits mode/mux selects/LUT init atomically.
module logic_cell_cfg_loader #(
    parameter logic [5:0] CELL_ADDR = 6'd0,
    parameter logic [3:0] SYNC      = 4'hA
) (
    input  logic                           QCK,
    input  logic                           QRT,
    logic_cell_cfg_loader_if.slave         bus,
    output logic [1:0]                     mode,
    output logic                           bqz_sel,
    output logic                           cqz_sel,
    output logic                           qdi_sel,
    output logic [15:0]                    lut_init,
    output logic                           cfg_loaded,
    output logic                           cfg_done,
    output logic                           cfg_err,
    output logic [1:0]                     err_code
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [5:0] BCAST_ADDR = 6'h3F;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] shreg;
    logic        ready_q;
    logic        xfer;

    logic        sync_ok;
    logic        parity_ok;
    logic        mode_ok;
    logic        addr_ok;

    // ready_q is held high out of reset so IDLE accepts on the first free cycle;
    // the QRT gate forces ready low for the whole reset interval.
    assign bus.cfg_ready = ready_q & ~QRT;
    assign xfer          = bus.cfg_valid & bus.cfg_ready;

    assign sync_ok   = (shreg[3:0] == SYNC);
    assign parity_ok = ~(^shreg);
    assign mode_ok   = (shreg[5:4] != 2'd3);
    assign addr_ok   = (shreg[30:25] == CELL_ADDR) || (shreg[30:25] == BCAST_ADDR);

    always_ff @(posedge QCK) begin
        if (QRT) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            ready_q    <= 1'b1;
            mode       <= '0;
            bqz_sel    <= 1'b0;
            cqz_sel    <= 1'b0;
            qdi_sel    <= 1'b0;
            lut_init   <= '0;
            cfg_loaded <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
            err_code   <= '0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (bus.cfg_abort) begin
                        cnt   <= '0;
                        shreg <= '0;
                    end else if (xfer) begin
                        shreg[0] <= bus.cfg_bit;
                        cnt      <= 5'd1;
                        state    <= SHIFT;
                    end
                end

                SHIFT: begin
                    // Abort wins over a transfer in the same cycle; that bit is dropped.
                    if (bus.cfg_abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                        shreg <= '0;
                    end else if (xfer) begin
                        shreg[cnt] <= bus.cfg_bit;
                        if (cnt == 5'd31) begin
                            state   <= CHECK;
                            ready_q <= 1'b0;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end

                CHECK: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    if (!sync_ok) begin
                        cfg_err  <= 1'b1;
                        err_code <= 2'd1;
                    end else if (!parity_ok) begin
                        cfg_err  <= 1'b1;
                        err_code <= 2'd2;
                    end else if (!mode_ok) begin
                        cfg_err  <= 1'b1;
                        err_code <= 2'd3;
                    end else if (addr_ok) begin
                        mode       <= shreg[5:4];
                        bqz_sel    <= shreg[6];
                        cqz_sel    <= shreg[7];
                        qdi_sel    <= shreg[8];
                        lut_init   <= shreg[24:9];
                        cfg_loaded <= 1'b1;
                        cfg_done   <= 1'b1;
                        cfg_err    <= 1'b0;
                        err_code   <= '0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_cell_cfg_loader.sv
// Directed bench for logic_cell_cfg_loader: frames are hand-encoded constants and
// every expected output is written out per scenario.
module tb_logic_cell_cfg_loader;

    logic        QCK;
    logic        QRT;
    logic [1:0]  mode;
    logic        bqz_sel;
    logic        cqz_sel;
    logic        qdi_sel;
    logic [15:0] lut_init;
    logic        cfg_loaded;
    logic        cfg_done;
    logic        cfg_err;
    logic [1:0]  err_code;

    int unsigned pass_cnt;
    int unsigned total_cnt;

    logic_cell_cfg_loader_if bus ();

    logic_cell_cfg_loader #(
        .CELL_ADDR (6'd0),
        .SYNC      (4'hA)
    ) dut (
        .QCK        (QCK),
        .QRT        (QRT),
        .bus        (bus.slave),
        .mode       (mode),
        .bqz_sel    (bqz_sel),
        .cqz_sel    (cqz_sel),
        .qdi_sel    (qdi_sel),
        .lut_init   (lut_init),
        .cfg_loaded (cfg_loaded),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .err_code   (err_code)
    );

    logic [20:0] cfg_out;
    logic [25:0] all_out;
    assign cfg_out = {mode, bqz_sel, cqz_sel, qdi_sel, lut_init};
    assign all_out = {cfg_out, cfg_loaded, cfg_done, cfg_err, err_code};

    initial QCK = 1'b0;
    always #5 QCK = ~QCK;

    // Hand-encoded frames: {par, addr[5:0], lut[15:0], qdi, cqz, bqz, mode[1:0], sync[3:0]}
    localparam logic [31:0] F1     = 32'h8100_006A; // mode2 bqz1 lut8000 addr0
    localparam logic [31:0] F1_BAD = 32'h0100_006A; // F1 with bit 31 flipped
    localparam logic [31:0] F2     = 32'h0024_699A; // mode1 cqz1 qdi1 lut1234 addr0
    localparam logic [31:0] F_SYNC = 32'h0100_0065; // sync=5 and odd parity
    localparam logic [31:0] F_MODE = 32'h0000_003A; // mode3, good sync/parity
    localparam logic [31:0] F_ADR1 = 32'h0300_006A; // F1 fields, addr=1
    localparam logic [31:0] F_BC   = 32'hFF00_006A; // F1 fields, addr=3F

    localparam logic [20:0] C1 = {2'd2, 1'b1, 1'b0, 1'b0, 16'h8000};
    localparam logic [20:0] C2 = {2'd1, 1'b0, 1'b1, 1'b1, 16'h1234};

    // Returns 1 ns after the edge that accepted the last requested bit.
    task automatic send_frame(input logic [31:0] f, input int unsigned nbits, input bit rnd);
        int unsigned i;
        int unsigned budget;
        logic xfer;
        i = 0;
        budget = 0;
        while (i < nbits && budget < 1000) begin
            bus.cfg_bit   = f[i];
            bus.cfg_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            xfer = bus.cfg_valid & bus.cfg_ready;
            @(posedge QCK);
            #1;
            budget++;
            if (xfer) i++;
        end
        bus.cfg_valid = 1'b0;
        if (i < nbits) begin
            total_cnt++;
            $display("FAIL send_timeout: sent %0d bits, required %0d", i, nbits);
        end
    endtask

    task automatic expect_commit(input string name, input logic [20:0] exp_cfg);
        total_cnt++;
        if ({cfg_done, bus.cfg_ready} !== 2'b00)
            $display("FAIL %s_check_cycle: done/ready=%b required 00", name, {cfg_done, bus.cfg_ready});
        else pass_cnt++;
        // A bit offered while the loader is in CHECK must not be consumed.
        bus.cfg_bit   = 1'b1;
        bus.cfg_valid = 1'b1;
        @(posedge QCK);
        #1;
        bus.cfg_valid = 1'b0;
        total_cnt++;
        if ({cfg_done, cfg_loaded, cfg_err, err_code} !== 5'b11000)
            $display("FAIL %s_status: done/loaded/err/code=%b required 11000", name,
                     {cfg_done, cfg_loaded, cfg_err, err_code});
        else pass_cnt++;
        total_cnt++;
        if (cfg_out !== exp_cfg)
            $display("FAIL %s_outputs: got %h required %h", name, cfg_out, exp_cfg);
        else pass_cnt++;
        @(posedge QCK);
        #1;
        total_cnt++;
        if (cfg_done !== 1'b0)
            $display("FAIL %s_done_pulse: done=%b required 0", name, cfg_done);
        else pass_cnt++;
    endtask

    task automatic expect_nocommit(input string name, input logic exp_err, input logic [1:0] exp_code,
                                   input logic [20:0] held_cfg);
        @(posedge QCK);
        #1;
        total_cnt++;
        if ({cfg_done, cfg_err, err_code} !== {1'b0, exp_err, exp_code})
            $display("FAIL %s_status: done/err/code=%b required %b", name,
                     {cfg_done, cfg_err, err_code}, {1'b0, exp_err, exp_code});
        else pass_cnt++;
        total_cnt++;
        if (cfg_out !== held_cfg)
            $display("FAIL %s_held: got %h required %h", name, cfg_out, held_cfg);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        QRT = 1'b1;
        bus.cfg_bit = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_abort = 1'b0;
        repeat (3) @(posedge QCK);
        #1;
        total_cnt++;
        if (all_out !== '0) $display("FAIL reset_outputs: got %h required 0", all_out);
        else pass_cnt++;
        total_cnt++;
        if (bus.cfg_ready !== 1'b0) $display("FAIL reset_ready: got %b required 0", bus.cfg_ready);
        else pass_cnt++;
        QRT = 1'b0;
        @(posedge QCK);
        #1;
        total_cnt++;
        if ({bus.cfg_ready, cfg_loaded} !== 2'b10)
            $display("FAIL idle_ready: ready/loaded=%b required 10", {bus.cfg_ready, cfg_loaded});
        else pass_cnt++;
    endtask

    task automatic test_valid_frame();
        send_frame(F1, 32, 1'b0);
        expect_commit("frame1", C1);
    endtask

    task automatic test_parity_error();
        send_frame(F1_BAD, 32, 1'b0);
        expect_nocommit("parity_err", 1'b1, 2'd2, C1);
        send_frame(F2, 32, 1'b0);
        expect_commit("recover", C2);
    endtask

    task automatic test_sync_mode_errors();
        send_frame(F_SYNC, 32, 1'b0);
        expect_nocommit("sync_err", 1'b1, 2'd1, C2);
        send_frame(F_MODE, 32, 1'b0);
        expect_nocommit("mode_err", 1'b1, 2'd3, C2);
    endtask

    task automatic test_address();
        send_frame(F_ADR1, 32, 1'b0);
        expect_nocommit("addr_drop", 1'b1, 2'd3, C2);
        send_frame(F_BC, 32, 1'b0);
        expect_commit("broadcast", C1);
    endtask

    task automatic test_random_valid();
        send_frame(F2, 32, 1'b1);
        expect_commit("rand_valid", C2);
    endtask

    task automatic test_abort();
        send_frame(F1, 12, 1'b0);
        bus.cfg_bit   = F1[12];
        bus.cfg_valid = 1'b1;
        bus.cfg_abort = 1'b1;
        @(posedge QCK);
        #1;
        bus.cfg_abort = 1'b0;
        bus.cfg_valid = 1'b0;
        total_cnt++;
        if ({cfg_done, cfg_err, cfg_out} !== {2'b00, C2})
            $display("FAIL abort_held: done/err/cfg=%h required %h", {cfg_done, cfg_err, cfg_out}, {2'b00, C2});
        else pass_cnt++;
        send_frame(F1, 32, 1'b0);
        expect_commit("after_abort", C1);
    endtask

    task automatic test_reset_mid_frame();
        send_frame(F2, 20, 1'b0);
        bus.cfg_bit   = F2[20];
        bus.cfg_valid = 1'b1;
        QRT = 1'b1;
        #1;
        total_cnt++;
        if (bus.cfg_ready !== 1'b0) $display("FAIL midrst_ready: got %b required 0", bus.cfg_ready);
        else pass_cnt++;
        @(posedge QCK);
        #1;
        bus.cfg_valid = 1'b0;
        QRT = 1'b0;
        total_cnt++;
        if (all_out !== '0) $display("FAIL midrst_outputs: got %h required 0", all_out);
        else pass_cnt++;
        @(posedge QCK);
        #1;
        send_frame(F2, 32, 1'b0);
        expect_commit("after_reset", C2);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        QRT = 1'b1;
        test_reset();
        test_valid_frame();
        test_parity_error();
        test_sync_mode_errors();
        test_address();
        test_random_valid();
        test_abort();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
